// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled line, mid-bit sampling, one-deep holding
// register with ready/read handshake, framing-error pulse and sticky overrun.
`timescale 1ns/1ps
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  input  logic       rd_en,
  output logic [7:0] dados_recepcao,
  output logic       rxReady,
  output logic       rxBusy,
  output logic       frameError,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [2:0]     idx_reg, idx_next;
  logic [7:0]     sh_reg, sh_next;
  logic           rx_meta, rx_s, rx_d;
  logic           byte_done, stop_bad;

  // rx is asynchronous; rx_d keeps the previous synchronized value for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        // edge, not level: a line stuck low never starts a frame
        if (rx_d && !rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_reg == CNT_HALF) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              cnt_next   = '0;
              idx_next   = '0;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            sh_next[idx_reg] = rx_s;
            cnt_next         = '0;
            if (idx_reg == 3'd7) state_next = STOP;
            else                 idx_next   = idx_reg + 3'd1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        // leave mid stop bit so a shortened stop bit is tolerated
        if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            if (rx_s) byte_done = 1'b1;
            else      stop_bad  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dados_recepcao <= 8'h00;
      rxReady        <= 1'b0;
      frameError     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frameError <= stop_bad;
      if (byte_done) begin
        // a read landing on the completion cycle frees the slot for the new byte
        if (!rxReady || rd_en) begin
          dados_recepcao <= sh_reg;
          rxReady        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_en && rxReady) begin
        rxReady <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign rxBusy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bench-side transmitter, holding-register model and a
// scoreboard checked by a monitor at every frame end (rxBusy falling).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS        = 16;
  localparam int STOP_TICK = OS / 2 + 9 * OS;

  logic       clk, reset, rx, tick, rd_en;
  logic [7:0] dados_recepcao;
  logic       rxReady, rxBusy, frameError, overrun;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tick(tick), .rd_en(rd_en),
    .dados_recepcao(dados_recepcao), .rxReady(rxReady), .rxBusy(rxBusy),
    .frameError(frameError), .overrun(overrun)
  );

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         ready;
    bit         ovr;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0, n_bad = 0;
  int         tick_div = 1, div_cnt = 0;
  int         busy_rises = 0;
  bit         busy_prev = 0, ferr_pending = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_ready = 0, m_ovr = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 0;
    forever begin
      @(negedge clk);
      if (div_cnt >= tick_div - 1) begin
        tick = 1;
        div_cnt = 0;
      end else begin
        tick = 0;
        div_cnt++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      rx = bits[k];
      wait_ticks(OS);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Reference model of the receive outcome: good bytes land if the slot is
  // free (or freed by a simultaneous read), otherwise overrun is raised.
  task automatic push_frame(input logic [7:0] b, input bit stop_ok, input bit rd_at_done);
    exp_t e;
    if (stop_ok) begin
      if (!m_ready || rd_at_done) begin
        m_data  = b;
        m_ready = 1;
      end else begin
        m_ovr = 1;
      end
    end
    e.ferr = !stop_ok; e.data = m_data; e.ready = m_ready; e.ovr = m_ovr;
    q.push_back(e);
  endtask

  task automatic push_glitch();
    exp_t e;
    e.ferr = 0; e.data = m_data; e.ready = m_ready; e.ovr = m_ovr;
    q.push_back(e);
  endtask

  task automatic do_read();
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    if (m_ready) begin
      m_ready = 0;
      m_ovr   = 0;
    end
    chk("read_rxReady", rxReady, m_ready);
    chk("read_overrun", overrun, m_ovr);
    chk("read_data", dados_recepcao, m_data);
    $display("read: data=%02h ready=%b ovr=%b", dados_recepcao, rxReady, overrun);
  endtask

  // With tick every clk, the stop sample is STOP_TICK clks after START entry.
  task automatic collide_read();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rxBusy && n < 400);
    n_cmp++;
    if (!rxBusy) begin
      n_bad++;
      $display("FAIL collide_start: got rxBusy=0, required 1 within 400 clk");
    end
    repeat (STOP_TICK - 1) @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  // Monitor: every frame end pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev    = 0;
        ferr_pending = 0;
      end else begin
        if (ferr_pending) begin
          chk("frameError_width", frameError, 0);
          ferr_pending = 0;
        end
        if (!busy_prev && rxBusy) busy_rises++;
        if (busy_prev && !rxBusy) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame_end: got data=%02h ready=%b, required no frame", dados_recepcao, rxReady);
          end else begin
            mon_e = q.pop_front();
            chk("frameError", frameError, mon_e.ferr);
            chk("dados_recepcao", dados_recepcao, mon_e.data);
            chk("rxReady", rxReady, mon_e.ready);
            chk("overrun", overrun, mon_e.ovr);
            if (mon_e.ferr) ferr_pending = 1;
            $display("frame end: data=%02h ready=%b ovr=%b ferr=%b", dados_recepcao, rxReady, overrun, frameError);
          end
        end
        busy_prev = rxBusy;
      end
    end
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         r;
    reset = 1; rx = 1; rd_en = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_data", dados_recepcao, 8'h00);
    chk("reset_rxReady", rxReady, 0);
    chk("reset_frameError", frameError, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_rxBusy", rxBusy, 0);
    idle(4);

    push_frame(8'hA5, 1, 0); drive_frame(8'hA5, 1, 10); idle(4);
    do_read();

    // short low pulse: false start
    r = busy_rises;
    push_glitch();
    @(negedge clk); rx = 0; wait_ticks(4);
    idle(24);
    chk("glitch_busy_pulse", busy_rises, r + 1);

    // stop bit low, then line held low
    push_frame(8'h3C, 0, 0); drive_frame(8'h3C, 0, 10);
    r = busy_rises;
    wait_ticks(40);
    chk("no_start_while_low", busy_rises, r);
    idle(4);

    push_frame(8'h11, 1, 0); drive_frame(8'h11, 1, 10); idle(4);
    push_frame(8'h22, 1, 0); drive_frame(8'h22, 1, 10); idle(4);
    do_read();

    push_frame(8'h11, 1, 0); drive_frame(8'h11, 1, 10); idle(4);
    push_frame(8'h22, 1, 1);
    fork
      drive_frame(8'h22, 1, 10);
      collide_read();
    join
    idle(4);

    // reset in the middle of data bit 4 of 0xFF
    drive_frame(8'hFF, 1, 5);
    @(negedge clk); rx = 1; wait_ticks(8);
    @(posedge clk); #2 reset = 1;
    #1;
    chk("async_data", dados_recepcao, 8'h00);
    chk("async_rxReady", rxReady, 0);
    chk("async_frameError", frameError, 0);
    chk("async_overrun", overrun, 0);
    chk("async_rxBusy", rxBusy, 0);
    m_data = 8'h00; m_ready = 0; m_ovr = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    idle(4);

    push_frame(8'h5A, 1, 0); drive_frame(8'h5A, 1, 10); idle(4);
    do_read();
    tick_div = 3;
    push_frame(8'h5A, 1, 0); drive_frame(8'h5A, 1, 10); idle(4);
    do_read();

    for (int i = 0; i < 24; i++) begin
      tick_div = $urandom_range(1, 3);
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) do_read();
      push_frame(b, ok, 0);
      drive_frame(b, ok, 10);
      idle(4);
    end
    do_read();

    wait_ticks(20);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the processor's UART. It sits on the line driven by the transmitter and turns the serial stream back into bytes. Frame format is 8N1: one low start bit, 8 data bits LSB first, one high stop bit. The line is sampled with an oversampling strobe, and each received byte is held in a one-deep holding register with a ready/read handshake. It flags framing errors and overruns.

## Interface
- OVERSAMPLE, 16: number of `tick` strobes per bit period. Must be an even value ≥ 4.

- clk  input  1  FPGA clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears the block immediately.
- rx  input  1  serial line, idle high; asynchronous to `clk`.
- tick  input  1  one-`clk` strobe at OVERSAMPLE × baud rate; counters advance only when `tick`=1.
- rd_en  input  1  consumer acknowledge; clears `rxReady`.
- dados_recepcao  output  8  last correctly received byte.
- rxReady  output  1  holding register holds an unread byte.
- rxBusy  output  1  a frame is in progress (state ≠ IDLE).
- frameError  output  1  one-`clk` pulse when a stop bit is sampled low.
- overrun  output  1  sticky flag; a byte was dropped because the holding register was full.

## Operation
- Synchronizer: 2-flop synchronizer on `rx` gives `rx_s`. A third flop `rx_d` holds the previous `rx_s`. All three flops reset to 1.
- Tick counter `cnt`: width is $clog2(OVERSAMPLE). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Start condition is a falling edge, `rx_d`=1 and `rx_s`=0. It is checked every `clk`, not only on `tick`.
  - On a falling edge: go to START and set `cnt`=0.
  - A line held low never starts a frame.
- START, on each `tick`:
  - If `cnt`=OVERSAMPLE/2−1, sample `rx_s` (mid start bit).
  - Sample is 1 (false start): go to IDLE with no flags set.
  - Sample is 0: set `cnt`=0 and `idx`=0, then go to DATA.
  - Otherwise, `cnt`++.
- DATA, on each `tick`:
  - If `cnt`=OVERSAMPLE−1, set `sh[idx]`←`rx_s` and `cnt`=0.
  - At that point, if `idx`=7 go to STOP; otherwise `idx`++.
  - Otherwise, `cnt`++.
- STOP, on each `tick`:
  - If `cnt`=OVERSAMPLE−1, sample `rx_s` and go to IDLE.
  - Sample is 1: the byte completes (see holding register).
  - Sample is 0: `frameError`=1 for the next `clk` only. The byte is discarded; `dados_recepcao`, `rxReady` and `overrun` are unchanged.
- Holding register, on byte completion:
  - `rxReady`=0: `dados_recepcao`←`sh`, `rxReady`←1.
  - `rxReady`=1 and `rd_en`=1 in the same cycle: `dados_recepcao`←`sh`, `rxReady` stays 1, `overrun` is unchanged.
  - `rxReady`=1 and `rd_en`=0: the new byte is dropped, old data is kept, `overrun`←1.
- `rd_en` with no completion in the same cycle: `rxReady`←0 and `overrun`←0. `rd_en` while `rxReady`=0 has no effect.
- `rxBusy` is combinational: state ≠ IDLE.

## Timing
- Reset values:
  - State is IDLE, `cnt`=0, `idx`=0, `sh`=0.
  - `dados_recepcao`=8'h00, `rxReady`=0, `frameError`=0, `overrun`=0, `rxBusy`=0.
  - Synchronizer flops are 1.
- Reset mid-frame: the partial byte is lost. The block is in IDLE on release and accepts the next falling edge.
- Edge detection lags the `rx` pin by 2 `clk`.
- Samples fall on bit centres: start bit at tick OVERSAMPLE/2, data bit k at tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE, stop bit at OVERSAMPLE/2 + 9·OVERSAMPLE ticks after the edge.
- `rxReady` and `frameError` assert on the `clk` after the `tick` that samples the stop bit.
- `rxBusy` falls on that same `clk`.
- The receiver is back in IDLE mid stop bit, so it tolerates up to half a bit of transmitter stop-bit shortening.

## Test plan
- Loopback from the transmitter, OVERSAMPLE=16, `tick` every clk, transmitter bit tick every 16 clk, send 8'hA5 -> `dados_recepcao`=8'hA5 and `rxReady`=1 one clk after the stop sample; `frameError`=0 and `overrun`=0.
- Glitch: `rx` low for 4 ticks, then high -> `rxBusy` pulses, then returns to 0; `rxReady`=0 and `frameError`=0.
- Frame 8'h3C with stop bit driven 0, line then held low for 40 ticks -> `frameError` high for exactly 1 clk; `rxReady`=0 and `dados_recepcao` unchanged; no new frame starts until `rx` goes high and then falls.
- Send 8'h11 then 8'h22 with no `rd_en` -> `dados_recepcao`=8'h11, `overrun`=1; then pulse `rd_en` -> `rxReady`=0 and `overrun`=0.
- `rxReady`=1 holding 8'h11; pulse `rd_en` exactly on the completion clk of 8'h22 -> `dados_recepcao`=8'h22, `rxReady`=1, `overrun`=0.
- Assert `reset` during DATA bit 4 of 8'hFF -> all outputs 0 immediately (async); after release, send 8'h5A -> received as 8'h5A; also repeat a frame with `tick` every 3 clk and confirm the same byte is received.
